// File: rtl/fa_coef_loader.sv
// Coefficient loader: streams DEPTH 16-bit words into a register file through a
// valid/ready handshake and exposes them on a combinational read port.
module fa_coef_loader #(
  parameter int WIDTH_A = 12,
  parameter int DEPTH   = 120
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [15:0]        in_data,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] rd_addr,
  output logic [15:0]        rd_coef,
  output logic [WIDTH_A-1:0] wr_count,
  output logic               busy,
  output logic               done,
  output logic               err_ovf
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH_A-1:0] LAST    = WIDTH_A'(DEPTH - 1);
  localparam logic [WIDTH_A-1:0] DEPTH_A = WIDTH_A'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t              state, state_next;
  logic [WIDTH_A-1:0]  count_next;
  logic                err_next;
  logic                wr_en;
  logic [15:0]         mem [DEPTH];

  // start has priority everywhere, so a word offered alongside it is dropped
  always_comb begin
    state_next = state;
    count_next = wr_count;
    err_next   = err_ovf;
    wr_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
          count_next = '0;
          err_next   = 1'b0;
        end
      end
      S_LOAD: begin
        if (start) begin
          count_next = '0;
          err_next   = 1'b0;
        end else if (in_valid) begin
          wr_en = 1'b1;
          if (wr_count == LAST) begin
            state_next = S_DONE;
            count_next = DEPTH_A;
          end else begin
            count_next = wr_count + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_next = S_LOAD;
          count_next = '0;
          err_next   = 1'b0;
        end else if (in_valid) begin
          err_next = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_count <= '0;
      err_ovf  <= 1'b0;
    end else begin
      state    <= state_next;
      wr_count <= count_next;
      err_ovf  <= err_next;
    end
  end

  // wr_count never exceeds DEPTH-1 while in LOAD, so the low bits index mem safely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_count[IW-1:0]] <= in_data;
    end
  end

  assign rd_coef  = (rd_addr < DEPTH_A) ? mem[rd_addr[IW-1:0]] : 16'h0000;
  assign busy     = (state == S_LOAD);
  assign in_ready = (state == S_LOAD);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_fa_coef_loader.sv
// Directed bench for fa_coef_loader: written words are queued on a scoreboard
// and popped against the read port once each load phase settles.
module tb_fa_coef_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_ready;
  logic [11:0] rd_addr = 12'd0;
  logic [15:0] rd_coef;
  logic [11:0] wr_count;
  logic        busy;
  logic        done;
  logic        err_ovf;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] model_mem [120];

  fa_coef_loader #(.WIDTH_A(12), .DEPTH(120)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .rd_addr  (rd_addr),
    .rd_coef  (rd_coef),
    .wr_count (wr_count),
    .busy     (busy),
    .done     (done),
    .err_ovf  (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic s, input logic v, input logic [15:0] d);
    start    = s;
    in_valid = v;
    in_data  = d;
  endtask

  task automatic push_word(input logic [11:0] a, input logic [15:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
    model_mem[a] = d;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_read(input string tag, input logic [11:0] a, input logic [15:0] exp);
    rd_addr = a;
    #1;
    check_output(tag, {16'h0000, rd_coef}, {16'h0000, exp});
  endtask

  task automatic check_status(input string tag, input logic b, input logic d,
                              input logic e, input logic [11:0] c);
    check_output({tag, "_busy"},  {31'd0, busy},     {31'd0, b});
    check_output({tag, "_ready"}, {31'd0, in_ready}, {31'd0, b});
    check_output({tag, "_done"},  {31'd0, done},     {31'd0, d});
    check_output({tag, "_err"},   {31'd0, err_ovf},  {31'd0, e});
    check_output({tag, "_count"}, {20'd0, wr_count}, {20'd0, c});
  endtask

  // Only call with start=0 and in_valid=0, so the #1 reads never race a transfer
  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_read(tag, e.addr, e.data);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 120; a++) model_mem[a] = 16'h0000;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_status("reset", 1'b0, 1'b0, 1'b0, 12'd0);
    check_read("reset_mem0", 12'd0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(1'b0, 1'b1, 16'h1234);
    tick();
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    check_status("idle_no_start", 1'b0, 1'b0, 1'b0, 12'd0);
    check_read("idle_mem0", 12'd0, 16'h0000);

    $display("[TB] back-to-back load");
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    check_status("start1", 1'b1, 1'b0, 1'b0, 12'd0);
    for (int i = 0; i < 120; i++) begin
      apply_stimulus(1'b0, 1'b1, 16'(i + 1));
      push_word(12'(i), 16'(i + 1));
      if (i == 119) begin
        check_output("pre_last_done", {31'd0, done}, 32'd0);
        check_output("pre_last_count", {20'd0, wr_count}, 32'd119);
      end
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    check_status("load1_done", 1'b0, 1'b1, 1'b0, 12'd120);
    check_read("addr0", 12'd0, 16'h0001);
    check_read("addr119", 12'd119, 16'h0078);
    drain("load1_mem");
    check_read("oob120", 12'd120, 16'h0000);
    check_read("oob4095", 12'd4095, 16'h0000);
    tick();

    $display("[TB] overflow in done");
    apply_stimulus(1'b0, 1'b1, 16'hBEEF);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    check_status("ovf", 1'b0, 1'b1, 1'b1, 12'd120);
    check_read("ovf_addr5", 12'd5, 16'h0006);
    for (int a = 0; a < 120; a++) check_read("ovf_mem", 12'(a), model_mem[a]);
    tick();
    tick();
    check_output("ovf_sticky", {31'd0, err_ovf}, 32'd1);
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    check_status("restart_from_done", 1'b1, 1'b0, 1'b0, 12'd0);
    check_read("retain5", 12'd5, 16'h0006);
    tick();

    $display("[TB] toggling valid load");
    begin
      int k;
      k = 0;
      for (int i = 0; i < 240; i++) begin
        if (i % 2 == 0) begin
          apply_stimulus(1'b0, 1'b1, 16'(16'h1000 + k));
          if (k == 7) check_read("entry7_old", 12'd7, 16'h0008);
          if (k == 119) check_output("toggle_pre_last_done", {31'd0, done}, 32'd0);
          push_word(12'(k), 16'(16'h1000 + k));
          tick();
          if (k == 7) check_read("entry7_new", 12'd7, 16'h1007);
          k++;
        end else begin
          apply_stimulus(1'b0, 1'b0, 16'h0000);
          tick();
          check_output("gap_hold", {20'd0, wr_count}, 32'(k));
        end
      end
    end
    check_status("load2_done", 1'b0, 1'b1, 1'b0, 12'd120);
    drain("load2_mem");

    $display("[TB] restart mid-load");
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    tick();
    for (int k = 0; k < 50; k++) begin
      apply_stimulus(1'b0, 1'b1, 16'(16'h2000 + k));
      push_word(12'(k), 16'(16'h2000 + k));
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    check_output("count50", {20'd0, wr_count}, 32'd50);
    apply_stimulus(1'b1, 1'b1, 16'hDEAD);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    check_status("mid_restart", 1'b1, 1'b0, 1'b0, 12'd0);
    drain("restart_mem");
    check_read("entry50_old", 12'd50, 16'h1032);
    apply_stimulus(1'b0, 1'b1, 16'h3000);
    model_mem[0] = 16'h3000;
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    check_output("count_after_restart", {20'd0, wr_count}, 32'd1);
    check_read("entry0_new", 12'd0, 16'h3000);
    check_read("entry1_kept", 12'd1, 16'h2001);
    tick();
    for (int k = 1; k < 30; k++) begin
      apply_stimulus(1'b0, 1'b1, 16'(16'h3000 + k));
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    check_output("count30", {20'd0, wr_count}, 32'd30);

    $display("[TB] reset mid-load");
    #2 rst_n = 1'b0;
    #1;
    check_status("reset_mid", 1'b0, 1'b0, 1'b0, 12'd0);
    for (int a = 0; a < 120; a++) check_read("reset_mem", 12'(a), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b1, 16'h5555);
    tick();
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    check_status("post_reset_idle", 1'b0, 1'b0, 1'b0, 12'd0);
    check_read("post_reset_mem0", 12'd0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
